expr_edit_buffer: RTL and testbench
===================================

// Module: expr_edit_buffer
// PURPOSE
//  Parametrised successor to the calculator's keyboard-fed token store. Holds up to DEPTH
//  WIDTH-bit tokens with an editing cursor: insert-at-cursor, backspace, cursor moves,
//  home/end and clear. On eval it streams the stored expression to the evaluator over a
//  valid/ready handshake. Sits between the keyboard pulse decoder and the evaluator.
// PARAMETERS
//  DEPTH  20                  max tokens stored (>=2)
//  WIDTH  8                   token width in bits
//  PTR_W  $clog2(DEPTH+1)     width of cursor/count (derived, do not override)
// PORTS
//  clock      in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  dataIn     in   WIDTH  token to insert
//  insert     in   1      1-cycle pulse: insert dataIn at cursor
//  del        in   1      1-cycle pulse: delete token left of cursor (backspace)
//  ptrLeft    in   1      1-cycle pulse: cursor - 1
//  ptrRight   in   1      1-cycle pulse: cursor + 1
//  ptrHome    in   1      1-cycle pulse: cursor = 0
//  ptrEnd     in   1      1-cycle pulse: cursor = count
//  clear      in   1      1-cycle pulse: empty buffer, abort any stream
//  eval       in   1      1-cycle pulse: start streaming tokens 0..count-1
//  out_data   out  WIDTH  streamed token
//  out_valid  out  1      out_data valid
//  out_ready  in   1      consumer accepts when out_valid & out_ready
//  out_last   out  1      high with the final token of a stream
//  count      out  PTR_W  tokens stored
//  cursor     out  PTR_W  cursor position, 0..count
//  full       out  1      count == DEPTH
//  empty      out  1      count == 0
//  busy       out  1      streaming in progress
//  err        out  1      1-cycle pulse: command rejected
// BEHAVIOUR
//  - Reset: storage, count, cursor, out_data = 0; out_valid, out_last, busy, err = 0;
//    empty = 1; full = 0; state IDLE. Reset mid-stream aborts it immediately.
//  - States: IDLE (editing), STREAM (output). All edits complete in 1 cycle; count/cursor
//    reflect the edit on the next edge.
//  - Simultaneous pulses: a single command per cycle, priority
//    clear > eval > insert > del > ptrLeft > ptrRight > ptrHome > ptrEnd; the rest are dropped.
//  - insert: mem[i+1]=mem[i] for cursor<=i<count; mem[cursor]=dataIn; cursor++, count++.
//    Full -> no change, err pulse.
//  - del: mem[i-1]=mem[i] for cursor<=i<count; cursor--, count--. cursor==0 -> no change, err.
//  - ptrLeft at 0 / ptrRight at count: saturate, no err. Home/End never err.
//  - clear: count=cursor=0 (contents beyond count are don't-care); legal in either state.
//  - eval in IDLE: empty -> err, stay IDLE. Otherwise STREAM next edge: rd=0, out_valid=1,
//    out_data=mem[rd], out_last=(rd==count-1), busy=1.
//  - STREAM: out_data/out_last held stable while out_valid & !out_ready. On handshake rd++;
//    handshake with out_last -> IDLE, out_valid=0, busy=0 on the next edge. Contents and
//    cursor preserved (re-eval re-streams the same expression).
//  - In STREAM every command except clear is ignored with an err pulse. clear drops
//    out_valid on the next edge, returns to IDLE, empties buffer.
//  - full/empty/count/cursor are registered-state combinational decodes; no extra latency.
// STRUCTURE
//  - Shared package calc_pkg: DEPTH/WIDTH defaults, state enum {IDLE, STREAM}, command
//    encoding plus priority constant, shared with the keyboard decoder and the evaluator.
//  - Sub-module edit_cell: one WIDTH-bit storage slot with hold / load / take-left /
//    take-right select; DEPTH instances form the array, top holds FSM, cursor, count and
//    the read mux.
// TESTING
//  - Insert 0x31,0x2B,0x32 -> count=3, cursor=3; eval, ready=1 -> 0x31,0x2B,0x32 on 3
//    consecutive cycles, out_last on 0x32, busy low next cycle.
//  - Buffer 0x31,0x32; ptrLeft; insert 0x2B -> stream 0x31,0x2B,0x32; then del -> 0x31,0x32,
//    cursor=1.
//  - Fill DEPTH=20 tokens -> full=1; insert -> err pulse, count stays 20; del at cursor=0
//    after ptrHome -> err, no change.
//  - eval on empty -> err, out_valid stays 0; insert+del in the same cycle -> only the insert
//    applied.
//  - Stream with out_ready toggled 1,0,0,1 -> out_data held through the stall, no token lost
//    or duplicated; insert mid-stream -> err, count unchanged.
//  - clear mid-stream -> out_valid=0 next cycle, count=0; async reset asserted mid-stream ->
//    all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator types: default sizes, FSM states, command encoding and edit-cell selects.
package calc_pkg;

  localparam int unsigned CALC_DEPTH = 20;
  localparam int unsigned CALC_WIDTH = 8;
  localparam int unsigned CMD_N      = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Lower encoding = higher priority when several pulses arrive together.
  typedef enum logic [3:0] {
    CMD_NONE   = 4'd0,
    CMD_CLEAR  = 4'd1,
    CMD_EVAL   = 4'd2,
    CMD_INSERT = 4'd3,
    CMD_DEL    = 4'd4,
    CMD_LEFT   = 4'd5,
    CMD_RIGHT  = 4'd6,
    CMD_HOME   = 4'd7,
    CMD_END    = 4'd8
  } cmd_e;

  typedef enum logic [1:0] {
    SEL_HOLD       = 2'd0,
    SEL_LOAD       = 2'd1,
    SEL_TAKE_LEFT  = 2'd2,
    SEL_TAKE_RIGHT = 2'd3
  } cell_sel_e;

  // Pulse vector bit order: [7]clear [6]eval [5]insert [4]del [3]left [2]right [1]home [0]end.
  function automatic cmd_e pick_cmd(input logic [CMD_N-1:0] pulses);
    cmd_e c;
    c = CMD_NONE;
    if      (pulses[7]) c = CMD_CLEAR;
    else if (pulses[6]) c = CMD_EVAL;
    else if (pulses[5]) c = CMD_INSERT;
    else if (pulses[4]) c = CMD_DEL;
    else if (pulses[3]) c = CMD_LEFT;
    else if (pulses[2]) c = CMD_RIGHT;
    else if (pulses[1]) c = CMD_HOME;
    else if (pulses[0]) c = CMD_END;
    return c;
  endfunction

endpackage

// File: rtl/edit_cell.sv
// One token slot of the edit buffer: hold, load a new token, or shift from a neighbour.
module edit_cell
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  cell_sel_e        sel_i,
  input  logic [WIDTH-1:0] load_i,
  input  logic [WIDTH-1:0] left_i,
  input  logic [WIDTH-1:0] right_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;

  // Slot register; shifting right on insert pulls from the left neighbour and vice versa.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      case (sel_i)
        SEL_LOAD:       data_q <= load_i;
        SEL_TAKE_LEFT:  data_q <= left_i;
        SEL_TAKE_RIGHT: data_q <= right_i;
        default:        data_q <= data_q;
      endcase
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/expr_edit_buffer.sv
// Cursor-edited token buffer that streams its contents to the evaluator on eval.
module expr_edit_buffer
  import calc_pkg::*;
#(
  parameter  int unsigned DEPTH = CALC_DEPTH,
  parameter  int unsigned WIDTH = CALC_WIDTH,
  localparam int unsigned PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             insert,
  input  logic             del,
  input  logic             ptrLeft,
  input  logic             ptrRight,
  input  logic             ptrHome,
  input  logic             ptrEnd,
  input  logic             clear,
  input  logic             eval,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [PTR_W-1:0] count,
  output logic [PTR_W-1:0] cursor,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             err
);

  state_e           state_q;
  logic [PTR_W-1:0] count_q, cursor_q, rd_q, rd_d;
  logic [WIDTH-1:0] out_data_q, rd_data;
  logic             out_valid_q, out_last_q, err_q;
  cmd_e             cmd;
  logic [WIDTH-1:0] mem [DEPTH];
  cell_sel_e        sel [DEPTH];

  assign full  = (count_q == PTR_W'(DEPTH));
  assign empty = (count_q == '0);

  // Collapse simultaneous pulses to the single highest-priority command.
  always_comb begin
    cmd = pick_cmd({clear, eval, insert, del, ptrLeft, ptrRight, ptrHome, ptrEnd});
  end

  // Per-slot select: insert opens a gap at the cursor, backspace closes the one left of it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = SEL_HOLD;
      if (state_q == ST_IDLE && cmd == CMD_INSERT && !full) begin
        if (PTR_W'(i) == cursor_q)
          sel[i] = SEL_LOAD;
        else if (PTR_W'(i) > cursor_q && PTR_W'(i) <= count_q)
          sel[i] = SEL_TAKE_LEFT;
      end else if (state_q == ST_IDLE && cmd == CMD_DEL && cursor_q != '0) begin
        if (PTR_W'(i + 1) >= cursor_q && PTR_W'(i + 1) < count_q)
          sel[i] = SEL_TAKE_RIGHT;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [WIDTH-1:0] left_w, right_w;
    if (i == 0) begin : g_left_edge
      assign left_w = '0;
    end else begin : g_left
      assign left_w = mem[i-1];
    end
    if (i == DEPTH - 1) begin : g_right_edge
      assign right_w = '0;
    end else begin : g_right
      assign right_w = mem[i+1];
    end
    edit_cell #(.WIDTH(WIDTH)) u_cell (
      .clock  (clock),
      .reset  (reset),
      .sel_i  (sel[i]),
      .load_i (dataIn),
      .left_i (left_w),
      .right_i(right_w),
      .data_o (mem[i])
    );
  end

  // Read mux: slot 0 when launching a stream, otherwise the slot after the one on the bus.
  always_comb begin
    rd_d    = (state_q == ST_IDLE) ? '0 : rd_q + PTR_W'(1);
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (PTR_W'(i) == rd_d) rd_data = mem[i];
    end
  end

  // Edit/stream FSM with cursor, count and registered stream outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      cursor_q    <= '0;
      rd_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (cmd == CMD_CLEAR) begin
        state_q     <= ST_IDLE;
        count_q     <= '0;
        cursor_q    <= '0;
        rd_q        <= '0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            case (cmd)
              CMD_EVAL: begin
                if (empty) begin
                  err_q <= 1'b1;
                end else begin
                  state_q     <= ST_STREAM;
                  rd_q        <= '0;
                  out_data_q  <= rd_data;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (count_q == PTR_W'(1));
                end
              end
              CMD_INSERT: begin
                if (full) begin
                  err_q <= 1'b1;
                end else begin
                  count_q  <= count_q + PTR_W'(1);
                  cursor_q <= cursor_q + PTR_W'(1);
                end
              end
              CMD_DEL: begin
                if (cursor_q == '0) begin
                  err_q <= 1'b1;
                end else begin
                  count_q  <= count_q - PTR_W'(1);
                  cursor_q <= cursor_q - PTR_W'(1);
                end
              end
              CMD_LEFT:  if (cursor_q != '0) cursor_q <= cursor_q - PTR_W'(1);
              CMD_RIGHT: if (cursor_q != count_q) cursor_q <= cursor_q + PTR_W'(1);
              CMD_HOME:  cursor_q <= '0;
              CMD_END:   cursor_q <= count_q;
              default:   ;
            endcase
          end
          ST_STREAM: begin
            if (cmd != CMD_NONE) err_q <= 1'b1;
            if (out_valid_q && out_ready) begin
              if (out_last_q) begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
              end else begin
                rd_q       <= rd_d;
                out_data_q <= rd_data;
                out_last_q <= (rd_d == count_q - PTR_W'(1));
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign count     = count_q;
  assign cursor    = cursor_q;
  assign busy      = (state_q == ST_STREAM);
  assign err       = err_q;

endmodule

// File: tb/tb_expr_edit_buffer.sv
// Randomised and directed bench for expr_edit_buffer against a queue-based reference model.
module tb_expr_edit_buffer;

  localparam int unsigned DEPTH = 20;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] dataIn;
  logic             insert, del, ptrLeft, ptrRight, ptrHome, ptrEnd, clear, eval;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_ready, out_last;
  logic [PTR_W-1:0] count, cursor;
  logic             full, empty, busy, err;

  expr_edit_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .dataIn(dataIn),
    .insert(insert), .del(del), .ptrLeft(ptrLeft), .ptrRight(ptrRight),
    .ptrHome(ptrHome), .ptrEnd(ptrEnd), .clear(clear), .eval(eval),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .count(count), .cursor(cursor), .full(full), .empty(empty), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: the expression as a queue plus cursor and stream position.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] snap[$];
  logic [WIDTH-1:0] rx[$];
  int               mcur;
  int               mrd;
  bit               mbusy;
  bit               merr;

  localparam logic [7:0] C_CLR = 8'h80, C_EVAL = 8'h40, C_INS = 8'h20, C_DEL = 8'h10;
  localparam logic [7:0] C_LEFT = 8'h08, C_RIGHT = 8'h04, C_HOME = 8'h02, C_END = 8'h01;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(mq.size()));
    check("cursor", 32'(cursor), 32'(mcur));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("busy", 32'(busy), 32'(mbusy));
    check("out_valid", 32'(out_valid), 32'(mbusy));
    check("err", 32'(err), 32'(merr));
    if (mbusy) begin
      check("out_data", 32'(out_data), 32'(mq[mrd]));
      check("out_last", 32'(out_last), 32'(mrd == mq.size() - 1));
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mcur  = 0;
    mrd   = 0;
    mbusy = 1'b0;
    merr  = 1'b0;
  endtask

  // Apply one cycle of pulses, advance the model by the same rules, then compare.
  task automatic step(input logic [7:0] c, input logic [WIDTH-1:0] d, input logic rdy);
    {clear, eval, insert, del, ptrLeft, ptrRight, ptrHome, ptrEnd} = c;
    dataIn    = d;
    out_ready = rdy;
    if (out_valid && rdy) rx.push_back(out_data);
    @(posedge clock);
    merr = 1'b0;
    if (c[7]) begin
      mq.delete();
      mcur  = 0;
      mbusy = 1'b0;
    end else if (mbusy) begin
      if (c != 8'h00) merr = 1'b1;
      if (rdy) begin
        if (mrd == mq.size() - 1) mbusy = 1'b0;
        else mrd++;
      end
    end else if (c[6]) begin
      if (mq.size() == 0) merr = 1'b1;
      else begin mbusy = 1'b1; mrd = 0; end
    end else if (c[5]) begin
      if (mq.size() == DEPTH) merr = 1'b1;
      else begin mq.insert(mcur, d); mcur++; end
    end else if (c[4]) begin
      if (mcur == 0) merr = 1'b1;
      else begin mq.delete(mcur - 1); mcur--; end
    end else if (c[3]) begin
      if (mcur > 0) mcur--;
    end else if (c[2]) begin
      if (mcur < mq.size()) mcur++;
    end else if (c[1]) begin
      mcur = 0;
    end else if (c[0]) begin
      mcur = mq.size();
    end
    #1;
    {clear, eval, insert, del, ptrLeft, ptrRight, ptrHome, ptrEnd} = 8'h00;
    check_all();
  endtask

  task automatic ins(input logic [WIDTH-1:0] d);
    step(C_INS, d, 1'b0);
  endtask

  // Launch a stream, drain it with a repeating ready pattern and compare received tokens.
  task automatic stream_and_check(input string tag, input logic [3:0] rdy_pat);
    int n;
    snap = mq;
    rx.delete();
    step(C_EVAL, '0, 1'b0);
    n = 0;
    while (busy && n < 200) begin
      step(8'h00, '0, rdy_pat[n % 4]);
      n++;
    end
    check({tag, "_timeout"}, 32'(busy), 32'(0));
    check({tag, "_len"}, 32'(rx.size()), 32'(snap.size()));
    for (int i = 0; i < snap.size() && i < rx.size(); i++)
      check({tag, "_tok"}, 32'(rx[i]), 32'(snap[i]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #12;
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    {clear, eval, insert, del, ptrLeft, ptrRight, ptrHome, ptrEnd} = 8'h00;
    dataIn    = '0;
    out_ready = 1'b0;
    reset     = 1'b0;
    do_reset();
    check_all();
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));

    // Basic insert and back-to-back stream.
    ins(8'h31); ins(8'h2B); ins(8'h32);
    stream_and_check("s1", 4'b1111);

    // Insert in the middle, then backspace.
    step(C_CLR, '0, 1'b0);
    ins(8'h31); ins(8'h32);
    step(C_LEFT, '0, 1'b0);
    ins(8'h2B);
    stream_and_check("s2", 4'b1111);
    step(C_DEL, '0, 1'b0);
    check("s2_cursor", 32'(cursor), 32'(1));

    // Full buffer, insert rejected; backspace at home rejected.
    step(C_CLR, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) ins(WIDTH'($urandom));
    ins(8'hEE);
    step(C_HOME, '0, 1'b0);
    step(C_DEL, '0, 1'b0);
    stream_and_check("s3", 4'b1011);

    // Eval on empty; insert+del together applies only the insert.
    step(C_CLR, '0, 1'b0);
    step(C_EVAL, '0, 1'b1);
    step(C_INS | C_DEL, 8'h41, 1'b0);
    step(C_LEFT | C_HOME, '0, 1'b0);
    step(C_RIGHT | C_END, '0, 1'b0);
    ins(8'h42); ins(8'h43);

    // Stalled stream with an insert attempt mid-stream.
    snap = mq;
    rx.delete();
    step(C_EVAL, '0, 1'b0);
    step(8'h00, '0, 1'b1);
    step(C_INS, 8'h99, 1'b0);
    step(8'h00, '0, 1'b0);
    step(8'h00, '0, 1'b1);
    step(8'h00, '0, 1'b1);
    check("s5_len", 32'(rx.size()), 32'(snap.size()));
    for (int i = 0; i < snap.size() && i < rx.size(); i++)
      check("s5_tok", 32'(rx[i]), 32'(snap[i]));

    // Clear mid-stream.
    step(C_EVAL, '0, 1'b0);
    step(8'h00, '0, 1'b1);
    step(C_CLR, '0, 1'b0);

    // Asynchronous reset mid-stream, observed without a clock edge.
    ins(8'h51); ins(8'h52); ins(8'h53);
    step(C_EVAL, '0, 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("arst_out_data", 32'(out_data), 32'(0));
    check("arst_out_last", 32'(out_last), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Random command traffic.
    for (int n = 0; n < 1500; n++) begin
      int unsigned r;
      logic [7:0]  c;
      r = $urandom_range(0, 23);
      if (r < 8) c = 8'h01 << r;
      else if (r < 13) c = C_INS;
      else if (r < 15) c = 8'(($urandom & 8'h7F) | 8'h01);
      else c = 8'h00;
      if (r == 7 && $urandom_range(0, 3) != 0) c = C_END;
      step(c, WIDTH'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
